blackjack_hand_fsm: RTL
=======================

Name: blackjack_hand_fsm

Overview:
- Game controller directly downstream of the 1–10 card counter.
- Samples card values from the counter, deals two cards each to player and dealer, and accumulates both hands.
- Handles player hit/stand, plays the dealer to the stand threshold, and resolves the round into a 5-bit result vector.
- Totals go to the two-digit hex displays; the result drives the LEDs.

Parameters:
- DEALER_STAND, 17: dealer draws while dealer_hand < DEALER_STAND.
- BUST_LIMIT, 21: any hand total > BUST_LIMIT is a bust.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-high reset.
- card_in  input  5  current card value from the card counter; legal range 1..10.
- card_valid  input  1  card_in may be consumed this cycle.
- start  input  1  level from a switch; a rising edge begins a round.
- hit  input  1  level from a switch; a rising edge requests one player card.
- stand  input  1  level from a switch; a rising edge ends the player turn.
- player_hand  output  5  player total.
- dealer_hand  output  5  dealer total.
- result  output  5  bit0 player win, bit1 dealer win, bit2 push, bit3 player bust, bit4 dealer bust.
- card_take  output  1  one-cycle pulse when card_in is consumed.
- state_out  output  4  current state encoding, for debug.

Behaviour:
- Reset (asynchronous, reset_n=1):
  - state=IDLE.
  - player_hand=0, dealer_hand=0, result=0, card_take=0.
  - Edge-detect history registers for start, hit and stand are loaded with the current input levels, so no edge is seen on reset release.
- Edge detect: a request is prev=0 and now=1, registered on clock. Only one request is acted on per cycle, in priority start > stand > hit.
- Card acceptance:
  - A card is taken in a cycle where the state needs a card, card_valid=1 and 1 ≤ card_in ≤ 10.
  - card_in values 0 or 11..31 are ignored; the state holds and card_take stays 0.
  - card_take is asserted combinationally in the same cycle. The total updates on the next clock edge.
- States:
  - IDLE: totals hold their last values. A start edge clears both totals and result, then goes to DEAL_P1.
  - DEAL_P1 → DEAL_D1 → DEAL_P2 → DEAL_D2: each state waits for one card, adds it to the named hand, then advances.
  - DEAL_D2 goes to PLAYER_TURN.
  - PLAYER_TURN:
    - A hit edge sets a pending flag. The next accepted card is added to player_hand.
    - If the new total > BUST_LIMIT, go to RESOLVE.
    - If the new total == BUST_LIMIT, go to DEALER_TURN (auto-stand).
    - A stand edge goes to DEALER_TURN.
    - A hit edge while a hit is already pending is ignored.
  - DEALER_TURN:
    - If dealer_hand ≥ DEALER_STAND, go to RESOLVE next cycle without taking a card.
    - Otherwise take one card and re-evaluate.
    - hit and stand edges are ignored.
  - RESOLVE (one cycle), first match wins:
    - player_hand > 21: bit3 and bit1.
    - dealer_hand > 21: bit4 and bit0.
    - player > dealer: bit0.
    - player < dealer: bit1.
    - Equal: bit2.
    - Then go to DONE.
  - DONE: totals and result hold. A start edge behaves as in IDLE (new round).
- Start mid-round: a start edge in any deal, turn or resolve state aborts the round. The block clears totals and result and goes to DEAL_P1 on the next cycle.
- Width:
  - Hard-count maximums are player 30 (20+10) and dealer 26 (16+10), so 5 bits is sufficient.
  - Additions are 5-bit unsigned with no saturation needed.
- Latency: with card_valid held at 1 and legal cards, a start edge leads to PLAYER_TURN after 4 card cycles plus 1 cycle.

Optional Feature:
- Macro: BLACKJACK_SOFT_ACE_EN.
- Defined:
  - Each hand keeps a has_ace flag.
  - The reported and compared total is hard+10 when has_ace=1 and hard ≤ 11; otherwise it is hard.
  - Bust, auto-stand, dealer-draw and resolve decisions all use the reported total.
  - A player's two-card 21 (ace plus 10) auto-stands.
- Undefined: aces count 1 only, and there is no has_ace logic.

Test Plan:
- Reset asserted mid-DEALER_TURN → all outputs 0 and state IDLE immediately, without waiting for a clock edge; start held high through release gives no round.
- Start edge, cards 10,9,7,8, stand edge → dealer 17 stands; player 17, dealer 17 → result=00100 (push).
- Cards 5,10,6,6, hit, card 10 → player 21 auto-stands; dealer draws 9 → 25 → result=10001.
- Cards 10,10,6,7, hit, card 9 → player 25 → result=01010; dealer takes no card (card_take stays 0).
- card_in=0 and then 12 with card_valid=1 during DEAL_P1 → no take and state holds; card_in=3 → taken, player_hand=3.
- BLACKJACK_SOFT_ACE_EN defined: cards 1,10,10,6 → player_hand=21 and auto-stand; dealer draws 5 → 21 → push. With the macro undefined, the same cards give player 11 and a PLAYER_TURN wait.

Source files
------------

// File: rtl/blackjack_hand_fsm.sv
// Blackjack round controller: deals from the card counter, runs player and dealer turns, resolves.
// Ports: clock, reset_n (async, active-high); card_in/card_valid from the counter, card_take consumes;
// start/hit/stand switch levels (rising edges act); player_hand/dealer_hand totals, result
// {dealer bust, player bust, push, dealer win, player win}, state_out for debug.
// Optional: BLACKJACK_SOFT_ACE_EN counts an ace as 11 while that keeps the hand at or under 21.
module blackjack_hand_fsm #(
  parameter int unsigned DEALER_STAND = 17,
  parameter int unsigned BUST_LIMIT   = 21
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] card_in,
  input  logic       card_valid,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  output logic [4:0] player_hand,
  output logic [4:0] dealer_hand,
  output logic [4:0] result,
  output logic       card_take,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2,
    S_PLAYER, S_DEALER, S_RESOLVE, S_DONE
  } state_e;

  localparam logic [4:0] STAND_L = 5'(DEALER_STAND);
  localparam logic [4:0] BUST_L  = 5'(BUST_LIMIT);

  state_e     state_q, state_d;
  logic [4:0] p_hard_q, p_hard_d;
  logic [4:0] d_hard_q, d_hard_d;
  logic [4:0] result_q, result_d;
  logic       hit_pend_q, hit_pend_d;
  logic       start_prev_q, hit_prev_q, stand_prev_q;

  logic       start_req, stand_req, hit_req;
  logic       card_ok, p_add, d_add, clr;
  logic [4:0] p_tot, d_tot, p_new;

`ifdef BLACKJACK_SOFT_ACE_EN
  logic p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic is_ace;

  function automatic logic [4:0] soft(input logic [4:0] h, input logic a);
    return (a && h <= 5'd11) ? h + 5'd10 : h;
  endfunction

  assign is_ace = (card_in == 5'd1);
  assign p_tot  = soft(p_hard_q, p_ace_q);
  assign d_tot  = soft(d_hard_q, d_ace_q);
  assign p_new  = soft(p_hard_q + card_in, p_ace_q | is_ace);
`else
  assign p_tot  = p_hard_q;
  assign d_tot  = d_hard_q;
  assign p_new  = p_hard_q + card_in;
`endif

  // One request per cycle: start beats stand beats hit.
  assign start_req = start & ~start_prev_q;
  assign stand_req = stand & ~stand_prev_q & ~start_req;
  assign hit_req   = hit & ~hit_prev_q & ~start_req & ~stand_req;

  assign card_ok = card_valid && (card_in >= 5'd1) && (card_in <= 5'd10);

  always_comb begin
    state_d    = state_q;
    p_hard_d   = p_hard_q;
    d_hard_d   = d_hard_q;
    result_d   = result_q;
    hit_pend_d = hit_pend_q;
    card_take  = 1'b0;
    p_add      = 1'b0;
    d_add      = 1'b0;
    clr        = 1'b0;
`ifdef BLACKJACK_SOFT_ACE_EN
    p_ace_d    = p_ace_q;
    d_ace_d    = d_ace_q;
`endif
    if (start_req) begin
      clr        = 1'b1;
      hit_pend_d = 1'b0;
      state_d    = S_DEAL_P1;
    end else begin
      unique case (state_q)
        S_DEAL_P1, S_DEAL_P2: begin
          if (card_ok) begin
            card_take = 1'b1;
            p_add     = 1'b1;
            state_d   = (state_q == S_DEAL_P1) ? S_DEAL_D1 : S_DEAL_D2;
          end
        end
        S_DEAL_D1, S_DEAL_D2: begin
          if (card_ok) begin
            card_take = 1'b1;
            d_add     = 1'b1;
            state_d   = (state_q == S_DEAL_D1) ? S_DEAL_P2 : S_PLAYER;
          end
        end
        S_PLAYER: begin
          if (stand_req) begin
            hit_pend_d = 1'b0;
            state_d    = S_DEALER;
          end else if (p_tot == BUST_L) begin
            // natural 21 from the deal stands on its own
            state_d = S_DEALER;
          end else if (hit_pend_q && card_ok) begin
            card_take  = 1'b1;
            p_add      = 1'b1;
            hit_pend_d = 1'b0;
            if (p_new > BUST_L) state_d = S_RESOLVE;
            else if (p_new == BUST_L) state_d = S_DEALER;
          end else if (hit_req) begin
            hit_pend_d = 1'b1;
          end
        end
        S_DEALER: begin
          if (d_tot >= STAND_L) begin
            state_d = S_RESOLVE;
          end else if (card_ok) begin
            card_take = 1'b1;
            d_add     = 1'b1;
          end
        end
        S_RESOLVE: begin
          if (p_tot > BUST_L) result_d = 5'b01010;
          else if (d_tot > BUST_L) result_d = 5'b10001;
          else if (p_tot > d_tot) result_d = 5'b00001;
          else if (p_tot < d_tot) result_d = 5'b00010;
          else result_d = 5'b00100;
          state_d = S_DONE;
        end
        S_IDLE, S_DONE: state_d = state_q;
        default: state_d = S_IDLE;
      endcase
    end
    if (clr) begin
      p_hard_d = 5'd0;
      d_hard_d = 5'd0;
      result_d = 5'd0;
`ifdef BLACKJACK_SOFT_ACE_EN
      p_ace_d  = 1'b0;
      d_ace_d  = 1'b0;
`endif
    end
    if (p_add) begin
      p_hard_d = p_hard_q + card_in;
`ifdef BLACKJACK_SOFT_ACE_EN
      p_ace_d  = p_ace_q | is_ace;
`endif
    end
    if (d_add) begin
      d_hard_d = d_hard_q + card_in;
`ifdef BLACKJACK_SOFT_ACE_EN
      d_ace_d  = d_ace_q | is_ace;
`endif
    end
  end

  // Edge history loads the live levels in reset so release creates no edge.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      state_q      <= S_IDLE;
      p_hard_q     <= 5'd0;
      d_hard_q     <= 5'd0;
      result_q     <= 5'd0;
      hit_pend_q   <= 1'b0;
      start_prev_q <= start;
      hit_prev_q   <= hit;
      stand_prev_q <= stand;
`ifdef BLACKJACK_SOFT_ACE_EN
      p_ace_q      <= 1'b0;
      d_ace_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      p_hard_q     <= p_hard_d;
      d_hard_q     <= d_hard_d;
      result_q     <= result_d;
      hit_pend_q   <= hit_pend_d;
      start_prev_q <= start;
      hit_prev_q   <= hit;
      stand_prev_q <= stand;
`ifdef BLACKJACK_SOFT_ACE_EN
      p_ace_q      <= p_ace_d;
      d_ace_q      <= d_ace_d;
`endif
    end
  end

  assign player_hand = p_tot;
  assign dealer_hand = d_tot;
  assign result      = result_q;
  assign state_out   = state_q;

endmodule
